// File: rtl/pc_fetch.sv
// Instruction fetch program counter with BOOT/RUN/HALT/FAULT sequencing.
// Drives the instruction memory word address and qualifies the returned word for decode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | one settling clock after reset release, pc held
// S_RUN   | fetching; pc advances, branches, or stops
// S_HALT  | EBREAK retired; terminal until reset
// S_FAULT | pc out of range or misaligned branch; terminal until reset

module pc_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int          IMEM_DEPTH = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] inst_in,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired_cnt
);

    localparam logic [33:0] PC_LIMIT   = 34'(4 * IMEM_DEPTH);
    localparam logic [31:0] INST_NOP   = 32'h00000013;
    localparam logic [31:0] INST_EBRK  = 32'h00100073;
    localparam logic [31:0] CNT_MAX    = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_retired;
    logic [31:0] w_retired_nxt;
    logic        w_retire;
    logic        w_in_range;
    logic        w_valid;

    // Widened compare so a limit near 2^32 cannot wrap.
    assign w_in_range = ({2'b00, r_pc} < PC_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_retire    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!w_in_range) begin
                    w_state_nxt = S_FAULT;
                end else if (!stall) begin
                    if (inst_in == INST_EBRK) begin
                        w_state_nxt = S_HALT;
                        w_retire    = 1'b1;
                    end else if (branch_taken) begin
                        if (branch_target[1:0] != 2'b00) begin
                            w_state_nxt = S_FAULT;
                        end else begin
                            w_pc_nxt = branch_target;
                            w_retire = 1'b1;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                        w_retire = 1'b1;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    assign w_retired_nxt = (w_retire && (r_retired != CNT_MAX)) ? r_retired + 32'd1 : r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_BOOT;
            r_pc      <= RESET_PC;
            r_retired <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    assign w_valid     = (r_state == S_RUN) && w_in_range;
    assign inst_valid  = w_valid;
    assign inst_out    = w_valid ? inst_in : INST_NOP;
    assign imem_addr   = {2'b00, r_pc[31:2]};
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign halted      = (r_state == S_HALT);
    assign fault       = (r_state == S_FAULT);
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: two instances (default depth and depth 4) against a rule-level model,
// plus directed scenarios with literal expectations.

module tb_pc_fetch;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] EBRK = 32'h00100073;
    localparam int M_BOOT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    logic [31:0] d_inst_in  [2];
    logic [31:0] d_addr     [2];
    logic [31:0] d_pc       [2];
    logic [31:0] d_plus4    [2];
    logic [31:0] d_inst_out [2];
    logic        d_valid    [2];
    logic        d_halted   [2];
    logic        d_fault    [2];
    logic [31:0] d_ret      [2];

    int total;
    int bad;

    int          m_st  [2];
    logic [31:0] m_pc  [2];
    logic [31:0] m_ret [2];

    assign d_inst_in[0] = (d_addr[0] < 32'd64) ? mem0[d_addr[0][5:0]] : 32'h0;
    assign d_inst_in[1] = (d_addr[1] < 32'd64) ? mem1[d_addr[1][5:0]] : 32'h0;

    pc_fetch u_dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .inst_in(d_inst_in[0]),
        .imem_addr(d_addr[0]), .pc(d_pc[0]), .pc_plus4(d_plus4[0]),
        .inst_out(d_inst_out[0]), .inst_valid(d_valid[0]), .halted(d_halted[0]),
        .fault(d_fault[0]), .retired_cnt(d_ret[0])
    );

    pc_fetch #(.IMEM_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .inst_in(d_inst_in[1]),
        .imem_addr(d_addr[1]), .pc(d_pc[1]), .pc_plus4(d_plus4[1]),
        .inst_out(d_inst_out[1]), .inst_valid(d_valid[1]), .halted(d_halted[1]),
        .fault(d_fault[1]), .retired_cnt(d_ret[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth_of(input int k);
        return (k == 0) ? 60 : 4;
    endfunction

    function automatic logic [31:0] mem_rd(input int k, input logic [31:0] byte_addr);
        logic [5:0] idx;
        idx = byte_addr[7:2];
        return (k == 0) ? mem0[idx] : mem1[idx];
    endfunction

    function automatic logic in_range(input int k, input logic [31:0] a);
        longint unsigned lim;
        lim = 64'(4 * depth_of(k));
        return (longint'(a) < lim);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Rule-level model: what each instance must do on every edge.
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            int          st;
            logic [31:0] npc;
            logic [31:0] nret;
            logic        adv;
            st   = m_st[k];
            npc  = m_pc[k];
            nret = m_ret[k];
            adv  = 1'b0;
            if (rst) begin
                st   = M_BOOT;
                npc  = 32'h0;
                nret = 32'h0;
            end else if (m_st[k] == M_BOOT) begin
                st = M_RUN;
            end else if (m_st[k] == M_RUN) begin
                if (!in_range(k, m_pc[k])) st = M_FAULT;
                else if (!stall) begin
                    if (mem_rd(k, m_pc[k]) == EBRK) begin
                        st  = M_HALT;
                        adv = 1'b1;
                    end else if (branch_taken && (branch_target % 4 != 0)) begin
                        st = M_FAULT;
                    end else begin
                        npc = branch_taken ? branch_target : m_pc[k] + 32'd4;
                        adv = 1'b1;
                    end
                end
            end
            if (adv && nret != 32'hFFFFFFFF) nret = nret + 1;
            m_st[k]  <= st;
            m_pc[k]  <= npc;
            m_ret[k] <= nret;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        ev;
            logic [31:0] ein;
            ev  = (m_st[k] == M_RUN) && in_range(k, m_pc[k]);
            ein = ev ? mem_rd(k, m_pc[k]) : NOP;
            chk($sformatf("d%0d.pc", k),       d_pc[k],       m_pc[k]);
            chk($sformatf("d%0d.imem_addr", k), d_addr[k],    m_pc[k] / 4);
            chk($sformatf("d%0d.pc_plus4", k), d_plus4[k],    m_pc[k] + 32'd4);
            chk($sformatf("d%0d.inst_valid", k), 32'(d_valid[k]), 32'(ev));
            chk($sformatf("d%0d.inst_out", k), d_inst_out[k], ein);
            chk($sformatf("d%0d.halted", k),   32'(d_halted[k]), 32'(m_st[k] == M_HALT));
            chk($sformatf("d%0d.fault", k),    32'(d_fault[k]),  32'(m_st[k] == M_FAULT));
            chk($sformatf("d%0d.retired", k),  d_ret[k],      m_ret[k]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        @(negedge clk);
        chk("rst.pc", d_pc[0], 32'h0);
        chk("rst.valid", 32'(d_valid[0]), 32'h0);
        chk("rst.inst_out", d_inst_out[0], NOP);
        chk("rst.addr", d_addr[0], 32'h0);
        chk("rst.plus4", d_plus4[0], 32'h4);
        chk("rst.flags", {30'h0, d_halted[0], d_fault[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 64; i++) begin
            mem0[i] = NOP;
            mem1[i] = NOP;
        end
    endtask

    logic [31:0] words [5];

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        words = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
        fill_nop();
        for (int i = 0; i < 5; i++) begin
            mem0[i] = words[i];
            mem1[i] = words[i];
        end

        // Straight-line run; depth-4 instance runs off the end of its memory.
        do_reset();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("seq.addr", d_addr[0], 32'(i));
            chk("seq.inst", d_inst_out[0], words[i]);
            chk("seq.ret", d_ret[0], 32'(i));
            if (i == 4) begin
                chk("range.pc", d_pc[1], 32'h10);
                chk("range.valid", 32'(d_valid[1]), 32'h0);
            end
            cyc();
        end
        chk("seq.ret5", d_ret[0], 32'd5);
        chk("seq.pc", d_pc[0], 32'h14);
        chk("range.fault", 32'(d_fault[1]), 32'h1);
        chk("range.pc_hold", d_pc[1], 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("async.pc1", d_pc[1], 32'h0);
        chk("async.fault1", 32'(d_fault[1]), 32'h0);
        chk("async.pc0", d_pc[0], 32'h0);
        chk("async.ret0", d_ret[0], 32'h0);

        // Stall with a pending branch, then release.
        fill_nop();
        do_reset();
        repeat (3) cyc();
        chk("br.pc8", d_pc[0], 32'h8);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h20;
        cyc();
        chk("stall.pc1", d_pc[0], 32'h8);
        cyc();
        chk("stall.pc2", d_pc[0], 32'h8);
        stall = 1'b0;
        cyc();
        chk("br.pc20", d_pc[0], 32'h20);
        chk("br.addr8", d_addr[0], 32'h8);
        branch_taken = 1'b0;
        cyc();

        // Misaligned branch target.
        do_reset();
        repeat (2) cyc();
        branch_taken = 1'b1;
        branch_target = 32'h22;
        cyc();
        chk("mis.fault", 32'(d_fault[0]), 32'h1);
        chk("mis.pc", d_pc[0], 32'h4);
        chk("mis.valid", 32'(d_valid[0]), 32'h0);
        chk("mis.ret", d_ret[0], 32'h1);
        branch_target = 32'h0;
        repeat (2) cyc();
        chk("mis.hold", d_pc[0], 32'h4);

        // EBREAK beats a simultaneous branch and is terminal.
        rst = 1'b1;
        mem0[3] = EBRK;
        do_reset();
        repeat (4) cyc();
        chk("eb.pcC", d_pc[0], 32'hC);
        branch_taken = 1'b1;
        branch_target = 32'h40;
        cyc();
        chk("eb.halted", 32'(d_halted[0]), 32'h1);
        chk("eb.pc", d_pc[0], 32'hC);
        chk("eb.ret", d_ret[0], 32'd4);
        repeat (3) cyc();
        chk("eb.hold_pc", d_pc[0], 32'hC);
        chk("eb.hold_fault", 32'(d_fault[0]), 32'h0);
        branch_taken = 1'b0;

        // Top-of-address-space pc: pc_plus4 wraps, range fault wins over stall.
        rst = 1'b1;
        mem0[3] = NOP;
        do_reset();
        cyc();
        branch_taken = 1'b1;
        branch_target = 32'hFFFFFFFC;
        cyc();
        chk("wrap.pc", d_pc[0], 32'hFFFFFFFC);
        chk("wrap.plus4", d_plus4[0], 32'h0);
        chk("wrap.addr", d_addr[0], 32'h3FFFFFFF);
        chk("wrap.valid", 32'(d_valid[0]), 32'h0);
        branch_taken = 1'b0;
        stall = 1'b1;
        cyc();
        chk("wrap.fault", 32'(d_fault[0]), 32'h1);
        chk("wrap.hold", d_pc[0], 32'hFFFFFFFC);
        stall = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
